// File: rtl/vec_pkg.sv
// Shared constants and types for the sequential vector ALU.
package vec_pkg;

  // Default geometry: 16 x 32-bit elements, 4 lanes per cycle.
  localparam int VEC_VLEN   = 512;
  localparam int VEC_ELEM_W = 32;
  localparam int VEC_LANES  = 4;

  // Operation encoding on op_code.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vec_alu_seq_if.sv
// Operand/result bus for the sequential vector ALU.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The source holds valid and its payload stable until that
// edge; ready may be high without valid. op_* goes requester -> ALU,
// res_* goes ALU -> consumer.
interface vec_alu_seq_if
  import vec_pkg::*;
#(
  parameter int VLEN   = VEC_VLEN,
  parameter int ELEM_W = VEC_ELEM_W
);
  localparam int NUM_ELEM = VLEN / ELEM_W;

  logic                op_valid;
  logic                op_ready;
  logic [1:0]          op_code;
  logic                op_sat;
  logic [VLEN-1:0]     src_a;
  logic [VLEN-1:0]     src_b;
  logic                res_valid;
  logic                res_ready;
  logic [VLEN-1:0]     res_lo;
  logic [VLEN-1:0]     res_hi;
  logic [NUM_ELEM-1:0] ovf;
  logic                busy;

  // Requester / result consumer side.
  modport master (
    output op_valid, op_code, op_sat, src_a, src_b, res_ready,
    input  op_ready, res_valid, res_lo, res_hi, ovf, busy
  );

  // ALU side.
  modport slave (
    input  op_valid, op_code, op_sat, src_a, src_b, res_ready,
    output op_ready, res_valid, res_lo, res_hi, ovf, busy
  );

endinterface

// File: rtl/vec_lane_unit.sv
// One signed element lane: ADD/SUB/MUL at double width with optional
// saturation of the low half, or signed MAX.
module vec_lane_unit
  import vec_pkg::*;
#(
  parameter int ELEM_W = VEC_ELEM_W
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [1:0]        op,
  input  logic              sat,
  output logic [ELEM_W-1:0] lo,
  output logic [ELEM_W-1:0] hi,
  output logic              ovf
);
  localparam int W2 = 2 * ELEM_W;
  localparam logic [ELEM_W-1:0] MAX_POS = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] MIN_NEG = {1'b1, {(ELEM_W-1){1'b0}}};

  logic signed [W2-1:0] w_a_ext;
  logic signed [W2-1:0] w_b_ext;
  logic signed [W2-1:0] w_r;
  logic                 w_fits;
  logic                 w_a_gt_b;

  // Sign-extending to 2W makes every ADD/SUB/MUL result exact.
  assign w_a_ext  = {{ELEM_W{a[ELEM_W-1]}}, a};
  assign w_b_ext  = {{ELEM_W{b[ELEM_W-1]}}, b};
  // R fits in W signed bits when its top W+1 bits are all equal.
  assign w_fits   = (&w_r[W2-1:ELEM_W-1]) | ~(|w_r[W2-1:ELEM_W-1]);
  assign w_a_gt_b = $signed(a) > $signed(b);

  // Exact double-width arithmetic result.
  always_comb begin
    w_r = '0;
    case (op)
      OP_ADD:  w_r = w_a_ext + w_b_ext;
      OP_SUB:  w_r = w_a_ext - w_b_ext;
      OP_MUL:  w_r = w_a_ext * w_b_ext;
      default: w_r = '0;
    endcase
  end

  // Split into lo/hi, flag overflow, clamp lo when saturating.
  always_comb begin
    lo  = '0;
    hi  = '0;
    ovf = 1'b0;
    if (op == OP_MAX) begin
      lo = w_a_gt_b ? a : b;
    end else begin
      hi  = w_r[W2-1:ELEM_W];
      ovf = ~w_fits;
      if (sat && !w_fits) begin
        lo = w_r[W2-1] ? MIN_NEG : MAX_POS;
      end else begin
        lo = w_r[ELEM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU: latches one operation, computes LANES_PER_CYCLE
// elements per clock, then holds the full result until it is consumed.
module vec_alu_seq
  import vec_pkg::*;
#(
  parameter int VLEN            = VEC_VLEN,
  parameter int ELEM_W          = VEC_ELEM_W,
  parameter int LANES_PER_CYCLE = VEC_LANES
) (
  input  logic              clk,
  input  logic              rst,
  vec_alu_seq_if.slave      bus,
  output state_t            o_dbg_state
);
  localparam int NUM_ELEM  = VLEN / ELEM_W;
  localparam int NUM_CHUNK = NUM_ELEM / LANES_PER_CYCLE;
  localparam int CNT_W     = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNK - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [VLEN-1:0]     r_a;
  logic [VLEN-1:0]     r_b;
  logic [1:0]          r_op;
  logic                r_sat;
  logic [VLEN-1:0]     r_lo;
  logic [VLEN-1:0]     r_hi;
  logic [NUM_ELEM-1:0] r_ovf;

  logic [ELEM_W-1:0]   w_a   [LANES_PER_CYCLE];
  logic [ELEM_W-1:0]   w_b   [LANES_PER_CYCLE];
  logic [ELEM_W-1:0]   w_lo  [LANES_PER_CYCLE];
  logic [ELEM_W-1:0]   w_hi  [LANES_PER_CYCLE];
  logic                w_ovf [LANES_PER_CYCLE];

  // Lanes see the chunk of latched operands selected by the counter.
  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    assign w_a[g] = r_a[(int'(r_cnt) * LANES_PER_CYCLE + g) * ELEM_W +: ELEM_W];
    assign w_b[g] = r_b[(int'(r_cnt) * LANES_PER_CYCLE + g) * ELEM_W +: ELEM_W];

    vec_lane_unit #(.ELEM_W(ELEM_W)) u_lane (
      .a   (w_a[g]),
      .b   (w_b[g]),
      .op  (r_op),
      .sat (r_sat),
      .lo  (w_lo[g]),
      .hi  (w_hi[g]),
      .ovf (w_ovf[g])
    );
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: accept in IDLE, walk the chunks in RUN, wait for the consumer in DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.op_valid)      w_next_state = S_RUN;
      S_RUN:  if (r_cnt == CNT_LAST) w_next_state = S_DONE;
      S_DONE: if (bus.res_ready)     w_next_state = S_IDLE;
      default:                       w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, chunk counter and result accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= OP_ADD;
      r_sat <= 1'b0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_ovf <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.op_valid) begin
            r_a   <= bus.src_a;
            r_b   <= bus.src_b;
            r_op  <= bus.op_code;
            r_sat <= bus.op_sat;
            r_cnt <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_ovf <= '0;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES_PER_CYCLE; l++) begin
            r_lo[(int'(r_cnt) * LANES_PER_CYCLE + l) * ELEM_W +: ELEM_W] <= w_lo[l];
            r_hi[(int'(r_cnt) * LANES_PER_CYCLE + l) * ELEM_W +: ELEM_W] <= w_hi[l];
            r_ovf[int'(r_cnt) * LANES_PER_CYCLE + l]                     <= w_ovf[l];
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.op_ready  = (r_state == S_IDLE);
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.res_lo    = r_lo;
  assign bus.res_hi    = r_hi;
  assign bus.ovf       = r_ovf;
  assign o_dbg_state   = r_state;

endmodule
